// File: rtl/traffic_light_pkg.sv
// Shared encodings for the four-way intersection controller.
// Optional pedestrian phase is enabled by defining TLC_PED_REQUEST_EN.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'b000,
    S_NS_YELLOW = 3'b001,
    S_EW_GREEN  = 3'b010,
    S_EW_YELLOW = 3'b011,
    S_PED_GREEN = 3'b100
  } tlc_state_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [1:0] PED_WALK      = 2'b10;
  localparam logic [1:0] PED_DONT_WALK = 2'b01;

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts 0..duration-1 and flags the last cycle of a phase.
// The owner clears it on every state change.
module tlc_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] duration,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Cycle counter within the current phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_r + ONE;
    end
  end

  assign expire = (count_r == (duration - ONE));

endmodule

// File: rtl/traffic_light_controller.sv
// Four-way intersection controller: NS/EW green-yellow cycle with an optional
// all-red pedestrian WALK phase, compiled in when TLC_PED_REQUEST_EN is defined.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int GREEN_DURATION  = 10,
  parameter int YELLOW_DURATION = 3,
  parameter int PED_DURATION    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedestrian_request,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [1:0] ped_light,
  output logic [2:0] current_state,
  output logic       ped_request_latched_out,
  output logic       was_in_ns_phase_out
);

  localparam int MAX_DUR_GY = (GREEN_DURATION > YELLOW_DURATION) ? GREEN_DURATION : YELLOW_DURATION;
  localparam int MAX_DUR    = (MAX_DUR_GY > PED_DURATION) ? MAX_DUR_GY : PED_DURATION;
  localparam int TW         = $clog2(MAX_DUR + 1);

  tlc_state_e    state_r;
  tlc_state_e    state_next_s;
  logic [TW-1:0] dur_s;
  logic          expire_s;
  logic          state_change_s;
  logic          phase_ns_r;
  logic          phase_ns_next_s;
  logic          latch_r;
  logic          latch_next_s;
  logic          ped_clear_s;

  tlc_phase_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_change_s),
    .duration (dur_s),
    .expire   (expire_s)
  );

  // Next-state selection, phase duration and light decode
  always_comb begin
    state_next_s = state_r;
    dur_s        = TW'(GREEN_DURATION);
    ns_light     = LIGHT_RED;
    ew_light     = LIGHT_RED;
    ped_light    = PED_DONT_WALK;
    case (state_r)
      S_NS_GREEN: begin
        ns_light = LIGHT_GREEN;
        dur_s    = TW'(GREEN_DURATION);
        if (expire_s) state_next_s = S_NS_YELLOW;
        else          state_next_s = state_r;
      end
      S_NS_YELLOW: begin
        ns_light = LIGHT_YELLOW;
        dur_s    = TW'(YELLOW_DURATION);
        if (expire_s) state_next_s = latch_r ? S_PED_GREEN : S_EW_GREEN;
        else          state_next_s = state_r;
      end
      S_EW_GREEN: begin
        ew_light = LIGHT_GREEN;
        dur_s    = TW'(GREEN_DURATION);
        if (expire_s) state_next_s = S_EW_YELLOW;
        else          state_next_s = state_r;
      end
      S_EW_YELLOW: begin
        ew_light = LIGHT_YELLOW;
        dur_s    = TW'(YELLOW_DURATION);
        if (expire_s) state_next_s = latch_r ? S_PED_GREEN : S_NS_GREEN;
        else          state_next_s = state_r;
      end
      S_PED_GREEN: begin
        ped_light = PED_WALK;
        dur_s     = TW'(PED_DURATION);
        // Resume in the direction that did not run last, so neither starves
        if (expire_s) state_next_s = phase_ns_r ? S_EW_GREEN : S_NS_GREEN;
        else          state_next_s = state_r;
      end
      default: begin
        state_next_s = S_NS_GREEN;
      end
    endcase
  end

  assign state_change_s = (state_next_s != state_r);
  assign ped_clear_s    = state_change_s && (state_next_s == S_PED_GREEN);

  // Phase flag tracks the most recently started vehicle direction
  always_comb begin
    phase_ns_next_s = phase_ns_r;
    if (state_change_s && (state_next_s == S_NS_GREEN)) begin
      phase_ns_next_s = 1'b1;
    end else if (state_change_s && (state_next_s == S_EW_GREEN)) begin
      phase_ns_next_s = 1'b0;
    end else begin
      phase_ns_next_s = phase_ns_r;
    end
  end

`ifdef TLC_PED_REQUEST_EN
  // A request on the clearing edge wins, so it is kept for the next yellow
  assign latch_next_s = (latch_r & ~ped_clear_s) | pedestrian_request;
`else
  logic unused_req_s;
  logic unused_clear_s;
  assign unused_req_s   = pedestrian_request;
  assign unused_clear_s = ped_clear_s;
  assign latch_next_s   = 1'b0;
`endif

  // State, phase flag and request latch registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_NS_GREEN;
      phase_ns_r <= 1'b1;
      latch_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      phase_ns_r <= phase_ns_next_s;
      latch_r    <= latch_next_s;
    end
  end

  assign current_state           = state_r;
  assign ped_request_latched_out = latch_r;
  assign was_in_ns_phase_out     = phase_ns_r;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: directed table, corner
// sequences (when TLC_PED_REQUEST_EN is defined) and random requests vs a phase-queue model.
module tb_traffic_light_controller;

  localparam int G = 10;
  localparam int Y = 3;
  localparam int P = 5;
`ifdef TLC_PED_REQUEST_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  localparam int NSG = 0, NSY = 1, EWG = 2, EWY = 3, PEDG = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pedestrian_request;
  logic [2:0] ns_light, ew_light, current_state;
  logic [1:0] ped_light;
  logic       ped_request_latched_out, was_in_ns_phase_out;

  traffic_light_controller #(
    .GREEN_DURATION (G),
    .YELLOW_DURATION(Y),
    .PED_DURATION   (P)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pedestrian_request     (pedestrian_request),
    .ns_light               (ns_light),
    .ew_light               (ew_light),
    .ped_light              (ped_light),
    .current_state          (current_state),
    .ped_request_latched_out(ped_request_latched_out),
    .was_in_ns_phase_out    (was_in_ns_phase_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one queue entry per remaining cycle of the current and scheduled phase
  int q[$];
  bit pend;
  bit flag;

  logic [2:0] ns_tab [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [5] = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [1:0] ped_tab[5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  function automatic void push_phase(int ph);
    int d;
    if (ph == NSG || ph == EWG) d = G;
    else if (ph == PEDG)        d = P;
    else                        d = Y;
    for (int i = 0; i < d; i++) q.push_back(ph);
  endfunction

  function automatic void model_reset();
    q.delete();
    push_phase(NSG);
    pend = 1'b0;
    flag = 1'b1;
  endfunction

  function automatic void model_edge(bit req);
    int cur, nxt;
    bit clr;
    clr = 1'b0;
    cur = q.pop_front();
    if (q.size() == 0) begin
      case (cur)
        NSG:     nxt = NSY;
        NSY:     nxt = pend ? PEDG : EWG;
        EWG:     nxt = EWY;
        EWY:     nxt = pend ? PEDG : NSG;
        default: nxt = flag ? EWG : NSG;
      endcase
      if (nxt == PEDG) clr = 1'b1;
      if (nxt == NSG)  flag = 1'b1;
      if (nxt == EWG)  flag = 1'b0;
      push_phase(nxt);
    end
    if (PED_EN) pend = (pend & ~clr) | req;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    int ph;
    ph = q[0];
    check({tag, ".state"}, 32'(current_state), 32'(ph));
    check({tag, ".ns"},    32'(ns_light),      32'(ns_tab[ph]));
    check({tag, ".ew"},    32'(ew_light),      32'(ew_tab[ph]));
    check({tag, ".ped"},   32'(ped_light),     32'(ped_tab[ph]));
    check({tag, ".latch"}, 32'(ped_request_latched_out), 32'(pend));
    check({tag, ".flag"},  32'(was_in_ns_phase_out),     32'(flag));
  endtask

  task automatic tick(bit req);
    pedestrian_request = req;
    @(posedge clk);
    model_edge(req);
    @(negedge clk);
    pedestrian_request = 1'b0;
    check_model("model");
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // Called while the bench sits at a falling edge
  task automatic apply_reset();
    reset = 1'b1;
    pedestrian_request = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int         advance;
    logic [2:0] st;
    logic [2:0] ns;
    logic [2:0] ew;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 3'b000, 3'b001, 3'b100};
    tbl[1] = '{9, 3'b000, 3'b001, 3'b100};
    tbl[2] = '{1, 3'b001, 3'b010, 3'b100};
    tbl[3] = '{2, 3'b001, 3'b010, 3'b100};
    tbl[4] = '{1, 3'b010, 3'b100, 3'b001};
    tbl[5] = '{9, 3'b010, 3'b100, 3'b001};
    tbl[6] = '{1, 3'b011, 3'b100, 3'b010};
    tbl[7] = '{2, 3'b011, 3'b100, 3'b010};
    tbl[8] = '{1, 3'b000, 3'b001, 3'b100};

    pedestrian_request = 1'b0;
    apply_reset();

    // Plain vehicle cycle, first pass from the table
    for (int i = 0; i < 9; i++) begin
      ticks(tbl[i].advance);
      check($sformatf("tbl%0d.state", i), 32'(current_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d.ns", i),    32'(ns_light),      32'(tbl[i].ns));
      check($sformatf("tbl%0d.ew", i),    32'(ew_light),      32'(tbl[i].ew));
      check($sformatf("tbl%0d.ped", i),   32'(ped_light),     32'(2'b01));
      check($sformatf("tbl%0d.latch", i), 32'(ped_request_latched_out), 32'(1'b0));
    end
    ticks(26);
    check("cycle2.state", 32'(current_state), 32'(3'b000));

`ifdef TLC_PED_REQUEST_EN
    // Request early in NS green: WALK after NS yellow, then EW green
    apply_reset();
    ticks(2);
    tick(1'b1);
    check("seqA.latch_set", 32'(ped_request_latched_out), 32'(1'b1));
    ticks(7);
    check("seqA.nsy", 32'(current_state), 32'(3'b001));
    ticks(3);
    check("seqA.ped_state", 32'(current_state), 32'(3'b100));
    check("seqA.ped_walk",  32'(ped_light), 32'(2'b10));
    check("seqA.ped_ns",    32'(ns_light),  32'(3'b100));
    check("seqA.ped_latch", 32'(ped_request_latched_out), 32'(1'b0));
    check("seqA.ped_flag",  32'(was_in_ns_phase_out), 32'(1'b1));
    tick(1'b1);
    ticks(3);
    check("seqA.ped_last", 32'(current_state), 32'(3'b100));
    tick(1'b0);
    check("seqA.ewg", 32'(current_state), 32'(3'b010));
    ticks(13);
    check("seqA.second_ped", 32'(current_state), 32'(3'b100));
    check("seqA.second_flag", 32'(was_in_ns_phase_out), 32'(1'b0));
    ticks(5);
    check("seqA.back_nsg", 32'(current_state), 32'(3'b000));

    // Request on the edge that enters WALK stays pending
    apply_reset();
    ticks(9);
    tick(1'b1);
    ticks(2);
    tick(1'b1);
    check("seqB.in_ped", 32'(current_state), 32'(3'b100));
    check("seqB.latch_kept", 32'(ped_request_latched_out), 32'(1'b1));
    ticks(18);
    check("seqB.next_ped", 32'(current_state), 32'(3'b100));

    // Reset during EW yellow with a pending request
    apply_reset();
    ticks(13);
    tick(1'b1);
    ticks(10);
    check("seqC.ewy", 32'(current_state), 32'(3'b011));
    check("seqC.latch", 32'(ped_request_latched_out), 32'(1'b1));
    reset = 1'b1;
    #1;
    check("seqC.rst_state", 32'(current_state), 32'(3'b000));
    check("seqC.rst_latch", 32'(ped_request_latched_out), 32'(1'b0));
    check("seqC.rst_flag",  32'(was_in_ns_phase_out), 32'(1'b1));
    check("seqC.rst_ns",    32'(ns_light), 32'(3'b001));
    #4;
    reset = 1'b0;
    @(negedge clk);
    apply_reset();
    ticks(9);
    check("seqC.nsg_full", 32'(current_state), 32'(3'b000));
`endif

    // Random requests with an occasional mid-run reset
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) apply_reset();
      tick($urandom_range(0, 14) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
